// File: rtl/decode_queue.sv
// Fetch-to-decode queue: circular buffer of fetched instructions with trap info and next-pc.
// Define DECODE_QUEUE_BYPASS_EN to forward an entry offered into an empty queue in the same cycle.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [31:0]              in_instr,
    input  logic                     in_exception,
    input  logic [3:0]               in_ecause,
    input  logic [XLEN-1:0]          in_etval,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_exception,
    output logic [3:0]               out_ecause,
    output logic [XLEN-1:0]          out_etval,
    output logic [XLEN-1:0]          out_npc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic            exc_mem   [DEPTH];
    logic [3:0]      ecause_mem[DEPTH];
    logic [XLEN-1:0] etval_mem [DEPTH];

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          full, empty, push, pop, wr_en;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count  = wr_ptr - rd_ptr;

    // in_ready looks only at local state so fetch never sees a path from decode's stall
    assign in_ready = !full && !flush && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready && !empty;

`ifdef DECODE_QUEUE_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = empty && push;
    assign out_valid  = (!empty || bypass_hit) && !flush;
    // a bypassed entry consumed in the same cycle never occupies a slot
    assign wr_en      = push && !(bypass_hit && out_ready);

    always_comb begin
        out_pc        = pc_mem[rd_idx];
        out_instr     = instr_mem[rd_idx];
        out_exception = exc_mem[rd_idx];
        out_ecause    = ecause_mem[rd_idx];
        out_etval     = etval_mem[rd_idx];
        if (bypass_hit) begin
            out_pc        = in_pc;
            out_instr     = in_instr;
            out_exception = in_exception;
            out_ecause    = in_ecause;
            out_etval     = in_etval;
        end
    end
`else
    assign out_valid     = !empty && !flush;
    assign wr_en         = push;
    assign out_pc        = pc_mem[rd_idx];
    assign out_instr     = instr_mem[rd_idx];
    assign out_exception = exc_mem[rd_idx];
    assign out_ecause    = ecause_mem[rd_idx];
    assign out_etval     = etval_mem[rd_idx];
`endif

    assign out_npc = out_pc + ((out_instr[1:0] == 2'b11) ? XLEN'(4) : XLEN'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]     <= '0;
                instr_mem[i]  <= '0;
                exc_mem[i]    <= 1'b0;
                ecause_mem[i] <= '0;
                etval_mem[i]  <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                pc_mem[wr_idx]     <= in_pc;
                instr_mem[wr_idx]  <= in_instr;
                exc_mem[wr_idx]    <= in_exception;
                ecause_mem[wr_idx] <= in_ecause;
                etval_mem[wr_idx]  <= in_etval;
                wr_ptr             <= wr_ptr + (AW+1)'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule
